div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//   Multi-cycle RV32M divide/remainder unit: DIV, DIVU, REM, REMU.
//   Sits beside the single-cycle ALU in the execute stage, with valid/ready handshakes on both sides.
//   The pipeline stalls while busy is high.
//   Restoring division: one quotient bit per clock. Divide-by-zero and signed overflow complete early.
// PARAMETERS
//   DWIDTH  32  operand/result width in bits (>= 2)
// PORTS
//   clk        in   1       single clock, rising edge
//   rst        in   1       synchronous, active-high reset
//   in_valid   in   1       request valid
//   in_ready   out  1       unit can accept a request (state == IDLE)
//   A          in   DWIDTH  dividend (rs1)
//   B          in   DWIDTH  divisor (rs2)
//   func       in   2       funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   out_valid  out  1       result valid
//   out_ready  in   1       consumer takes result
//   out        out  DWIDTH  quotient (DIV/DIVU) or remainder (REM/REMU)
//   busy       out  1       state != IDLE
// BEHAVIOUR
//   Reset (rst high at clk edge): state IDLE, all internal registers cleared.
//     Outputs after reset: out_valid=0, out=0, busy=0, in_ready=1.
//   Reset mid-operation: any in-flight request is discarded with no output. This applies in CALC and DONE.
//   States:
//     IDLE -> accept on in_valid && in_ready.
//       Latch A, B and func. Inputs may change after the accept cycle.
//       If B == 0 or a signed overflow is detected -> DONE. Otherwise -> CALC with count = 0.
//     CALC -> one restoring iteration per clock.
//       Shift remainder left, bringing in the next dividend magnitude bit, MSB first.
//       Trial-subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient bit.
//       After DWIDTH iterations (count == DWIDTH-1 at the edge) -> DONE.
//     DONE -> out and out_valid are held stable until out_valid && out_ready, then -> IDLE.
//       in_ready is 0 in DONE. No same-cycle accept is allowed.
//   Latency: request accepted in cycle t.
//     Normal: out_valid first high in cycle t+1+DWIDTH.
//     Special case: out_valid first high in cycle t+1.
//   Signed ops (DIV, REM):
//     Operate on magnitudes |A| and |B|.
//     Quotient is negated if A[MSB] != B[MSB].
//     Remainder takes the sign of A.
//     Negation is two's complement, truncated to DWIDTH.
//   Unsigned ops (DIVU, REMU): raw operands, no sign fix-up.
//   Divide by zero (B == 0), all funcs: quotient = all ones; remainder = A.
//   Signed overflow (DIV/REM, A = 1<<(DWIDTH-1), B = all ones): quotient = A; remainder = 0.
//   Invariant: A == q*B + r (mod 2^DWIDTH) for every non-zero-divisor case.
//   out is registered. out = 0 whenever out_valid = 0.
//   in_ready and busy are combinational decodes of state.
//   out_ready is ignored unless out_valid is high.
// TESTING
//   1. DIVU A=100, B=7 -> out=14, out_valid in cycle t+33. REMU same operands -> out=2.
//   2. DIV A=-7 (0xFFFFFFF9), B=2 -> out=0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1).
//   3. DIV A=0x80000000, B=0xFFFFFFFF -> out=0x80000000 at t+1. REM -> 0.
//   4. DIVU/DIV A=5, B=0 -> out=0xFFFFFFFF at t+1. REM/REMU A=5, B=0 -> out=5.
//   5. Hold out_ready=0 for 10 cycles in DONE -> out stable, in_ready=0, and the in_valid request is not taken.
//      Then pulse out_ready -> IDLE next cycle and the request is accepted.
//   6. Assert rst during CALC (count=10) -> next cycle IDLE, out_valid=0, out=0.
//      A fresh DIVU 9/3 then returns 3 with normal latency.

Source files
------------

// File: rtl/div_unit.sv
// RV32M divide/remainder unit: restoring division, one quotient bit per clock.
// Divide-by-zero and signed overflow bypass the iteration and complete in one cycle.
module div_unit #(
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DWIDTH-1:0] A,
   input  logic [DWIDTH-1:0] B,
   input  logic [1:0]        func,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out,
   output logic              busy
);

   localparam int CW = (DWIDTH > 2) ? $clog2(DWIDTH) : 1;
   localparam logic [DWIDTH-1:0] W_ONE  = {{(DWIDTH-1){1'b0}}, 1'b1};
   localparam logic [DWIDTH-1:0] W_MIN  = {1'b1, {(DWIDTH-1){1'b0}}};
   localparam logic [CW-1:0]     W_LAST = CW'(DWIDTH - 1);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // in_ready is high only in IDLE; out_valid is high only in DONE and holds out stable there.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CW-1:0]     r_count;
   logic [DWIDTH-1:0] r_dvd;     // dividend magnitude, quotient bits shift in at the LSB
   logic [DWIDTH-1:0] r_dvs;
   logic [DWIDTH-1:0] r_rem;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_is_rem;
   logic [DWIDTH-1:0] r_out;

   logic              w_accept;
   logic              w_signed;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [DWIDTH-1:0] w_a_mag;
   logic [DWIDTH-1:0] w_b_mag;
   logic              w_div0;
   logic              w_ovf;
   logic              w_special;
   logic [DWIDTH-1:0] w_special_res;
   logic [DWIDTH:0]   w_shift;
   logic [DWIDTH:0]   w_diff;
   logic              w_q_bit;
   logic [DWIDTH-1:0] w_rem_nxt;
   logic [DWIDTH-1:0] w_quo_nxt;
   logic [DWIDTH-1:0] w_quo_fix;
   logic [DWIDTH-1:0] w_rem_fix;
   logic [DWIDTH-1:0] w_calc_res;
   logic              w_last;

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign out       = r_out;

   assign w_accept  = in_valid && in_ready;
   assign w_signed  = ~func[0];
   assign w_a_neg   = w_signed & A[DWIDTH-1];
   assign w_b_neg   = w_signed & B[DWIDTH-1];
   assign w_a_mag   = w_a_neg ? ((~A) + W_ONE) : A;
   assign w_b_mag   = w_b_neg ? ((~B) + W_ONE) : B;
   assign w_div0    = ~|B;
   assign w_ovf     = w_signed && (A == W_MIN) && (&B);
   assign w_special = w_div0 || w_ovf;
   assign w_special_res = w_div0 ? (func[1] ? A : {DWIDTH{1'b1}})
                                 : (func[1] ? {DWIDTH{1'b0}} : A);

   // The shifted partial remainder needs one extra bit before the trial subtract.
   assign w_shift    = {r_rem, r_dvd[DWIDTH-1]};
   assign w_diff     = w_shift - {1'b0, r_dvs};
   assign w_q_bit    = ~w_diff[DWIDTH];
   assign w_rem_nxt  = w_q_bit ? w_diff[DWIDTH-1:0] : w_shift[DWIDTH-1:0];
   assign w_quo_nxt  = {r_dvd[DWIDTH-2:0], w_q_bit};
   assign w_quo_fix  = r_neg_q ? ((~w_quo_nxt) + W_ONE) : w_quo_nxt;
   assign w_rem_fix  = r_neg_r ? ((~w_rem_nxt) + W_ONE) : w_rem_nxt;
   assign w_calc_res = r_is_rem ? w_rem_fix : w_quo_fix;
   assign w_last     = (r_count == W_LAST);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_CALC;
         S_CALC: if (w_last) w_next = S_DONE;
         S_DONE: if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count  <= '0;
         r_dvd    <= '0;
         r_dvs    <= '0;
         r_rem    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_is_rem <= 1'b0;
         r_out    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_dvd    <= w_a_mag;
                  r_dvs    <= w_b_mag;
                  r_rem    <= '0;
                  r_count  <= '0;
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_is_rem <= func[1];
                  if (w_special) r_out <= w_special_res;
               end
            end
            S_CALC: begin
               r_dvd   <= w_quo_nxt;
               r_rem   <= w_rem_nxt;
               r_count <= r_count + CW'(1);
               if (w_last) r_out <= w_calc_res;
            end
            S_DONE: begin
               if (out_ready) r_out <= '0;
            end
            default: r_out <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotient/remainder vectors,
// latency, back-pressure in DONE and reset during an iteration.
module tb_div_unit;

   localparam int DW = 32;
   localparam logic [1:0] F_DIV  = 2'b00;
   localparam logic [1:0] F_DIVU = 2'b01;
   localparam logic [1:0] F_REM  = 2'b10;
   localparam logic [1:0] F_REMU = 2'b11;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] a_in;
   logic [DW-1:0] b_in;
   logic [1:0]    func;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;

   div_unit #(.DWIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (a_in),
      .B         (b_in),
      .func      (func),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one request for exactly one cycle, then scrambles the inputs.
   task automatic drive_req(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] f);
      check("in_ready_before_req", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      a_in     = a;
      b_in     = b;
      func     = f;
      step();
      in_valid = 1'b0;
      a_in     = $urandom;
      b_in     = $urandom;
      func     = 2'($urandom_range(0, 3));
   endtask

   // Called right after the accept edge; counts edges until out_valid rises.
   task automatic wait_result(input string tag, input int exp_lat, input logic [DW-1:0] exp_out);
      int cycles = 0;
      while (!out_valid && cycles < 100) begin
         step();
         cycles++;
      end
      check({tag, "_latency"}, DW'(cycles), DW'(exp_lat));
      check({tag, "_out"}, out, exp_out);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("after_consume_valid", {31'd0, out_valid}, 32'd0);
      check("after_consume_out", out, 32'd0);
      check("after_consume_ready", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [1:0] f, input int exp_lat, input logic [DW-1:0] exp_out);
      drive_req(a, b, f);
      wait_result(tag, exp_lat, exp_out);
      consume();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      a_in      = '0;
      b_in      = '0;
      func      = '0;
      out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_out", out, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);

      // Normal operations: 32 edges from accept to out_valid.
      run_op("divu_100_7",  32'd100,      32'd7,          F_DIVU, 32, 32'd14);
      run_op("remu_100_7",  32'd100,      32'd7,          F_REMU, 32, 32'd2);
      run_op("div_m7_2",    32'hFFFFFFF9, 32'd2,          F_DIV,  32, 32'hFFFFFFFD);
      run_op("rem_m7_2",    32'hFFFFFFF9, 32'd2,          F_REM,  32, 32'hFFFFFFFF);
      run_op("div_7_m2",    32'd7,        32'hFFFFFFFE,   F_DIV,  32, 32'hFFFFFFFD);
      run_op("rem_7_m2",    32'd7,        32'hFFFFFFFE,   F_REM,  32, 32'd1);
      run_op("div_m7_m2",   32'hFFFFFFF9, 32'hFFFFFFFE,   F_DIV,  32, 32'd3);
      run_op("rem_m7_m2",   32'hFFFFFFF9, 32'hFFFFFFFE,   F_REM,  32, 32'hFFFFFFFF);
      run_op("divu_max_1",  32'hFFFFFFFF, 32'd1,          F_DIVU, 32, 32'hFFFFFFFF);
      run_op("divu_min_m1", 32'h80000000, 32'hFFFFFFFF,   F_DIVU, 32, 32'd0);
      run_op("remu_min_m1", 32'h80000000, 32'hFFFFFFFF,   F_REMU, 32, 32'h80000000);
      run_op("div_min_1",   32'h80000000, 32'd1,          F_DIV,  32, 32'h80000000);
      run_op("rem_min_1",   32'h80000000, 32'd1,          F_REM,  32, 32'd0);
      run_op("divu_3_5",    32'd3,        32'd5,          F_DIVU, 32, 32'd0);
      run_op("remu_3_5",    32'd3,        32'd5,          F_REMU, 32, 32'd3);

      // Early completion: out_valid on the cycle right after accept.
      run_op("div_ovf",     32'h80000000, 32'hFFFFFFFF,   F_DIV,  0, 32'h80000000);
      run_op("rem_ovf",     32'h80000000, 32'hFFFFFFFF,   F_REM,  0, 32'd0);
      run_op("divu_5_0",    32'd5,        32'd0,          F_DIVU, 0, 32'hFFFFFFFF);
      run_op("div_5_0",     32'd5,        32'd0,          F_DIV,  0, 32'hFFFFFFFF);
      run_op("rem_5_0",     32'd5,        32'd0,          F_REM,  0, 32'd5);
      run_op("remu_5_0",    32'd5,        32'd0,          F_REMU, 0, 32'd5);
      run_op("rem_m8_0",    32'hFFFFFFF8, 32'd0,          F_REM,  0, 32'hFFFFFFF8);

      // Back-pressure: result held while a new request waits, then taken after the drain.
      drive_req(32'd200, 32'd10, F_DIVU);
      wait_result("bp_first", 32, 32'd20);
      in_valid = 1'b1;
      a_in     = 32'd9;
      b_in     = 32'd3;
      func     = F_DIVU;
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_hold_out", out, 32'd20);
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_drain_valid", {31'd0, out_valid}, 32'd0);
      check("bp_drain_out", out, 32'd0);
      check("bp_drain_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      a_in     = $urandom;
      b_in     = $urandom;
      check("bp_second_accepted", {31'd0, busy}, 32'd1);
      wait_result("bp_second", 32, 32'd3);
      consume();

      // Reset ten iterations into a calculation discards it.
      drive_req(32'd1000, 32'd7, F_DIVU);
      for (int i = 0; i < 10; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_out", out, 32'd0);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      begin
         int seen = 0;
         for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) seen++;
         end
         check("mid_rst_no_output", DW'(seen), 32'd0);
      end
      run_op("after_rst_divu_9_3", 32'd9, 32'd3, F_DIVU, 32, 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
